// File: rtl/tdm_demux_pkg.sv
// Shared constants and types for the nine-channel TDM demultiplexer.
// Optional feature macro: PARITY_EN (adds a tenth parity beat per frame).
package tdm_demux_pkg;

    localparam int NUM_CH = 9;

`ifdef PARITY_EN
    localparam int NUM_SLOTS = 10;
`else
    localparam int NUM_SLOTS = 9;
`endif

    localparam int SLOT_IDX_W = 4;

    // Index of the beat that closes a frame (slot 8, or the parity beat).
    localparam logic [SLOT_IDX_W-1:0] LAST_SLOT = SLOT_IDX_W'(NUM_SLOTS - 1);

    typedef enum logic {
        HUNT = 1'b0,
        RECV = 1'b1
    } state_e;

endpackage

// File: rtl/tdm_slot_counter.sv
// Frame alignment for the TDM demultiplexer: hunts for sync, tracks the slot
// index of each accepted beat, flags the frame-closing beat and sync restarts.
// Optional feature macro: PARITY_EN (frame length taken from the package).
module tdm_slot_counter
    import tdm_demux_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  sync,
    output logic                  accept,
    output logic [SLOT_IDX_W-1:0] slot_idx,
    output logic                  last_slot,
    output logic                  restart
);

    state_e                state_q, state_d;
    logic [SLOT_IDX_W-1:0] cnt_q, cnt_d;

    // State register: alignment state and index of the next expected slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= HUNT;
            cnt_q   <= '0;
        end else begin
            // NOTE: clocked state uses <= so every flop samples pre-edge values.
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic: sync always restarts at slot 0; en=0 holds everything.
    always_comb begin
        // NOTE: defaults first so no path leaves a variable unassigned (no latch).
        state_d = state_q;
        cnt_d   = cnt_q;
        if (en) begin
            unique case (state_q)
                HUNT: begin
                    if (sync) begin
                        state_d = RECV;
                        cnt_d   = SLOT_IDX_W'(1);
                    end
                end
                RECV: begin
                    if (sync) begin
                        cnt_d = SLOT_IDX_W'(1);
                    end else if (cnt_q == LAST_SLOT) begin
                        state_d = HUNT;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + SLOT_IDX_W'(1);
                    end
                end
                default: begin
                    state_d = HUNT;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Output decode: which slot the current beat lands in and frame events.
    always_comb begin
        accept    = en && (sync || (state_q == RECV));
        slot_idx  = sync ? '0 : cnt_q;
        restart   = en && sync && (state_q == RECV);
        last_slot = en && !sync && (state_q == RECV) && (cnt_q == LAST_SLOT);
    end

endmodule

// File: rtl/tdm_demux_9ch.sv
// Nine-channel TDM demultiplexer: steers framed slot words into a shadow
// register and publishes a complete registered frame with a valid pulse.
// Optional feature macro: PARITY_EN (tenth beat is an even-parity word;
// mismatching frames are dropped and flagged on parity_err).
module tdm_demux_9ch
    import tdm_demux_pkg::*;
#(
    parameter int DATA_W = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic                     sync,
    input  logic [DATA_W-1:0]        sdin,
    output logic [NUM_CH*DATA_W-1:0] dout,
    output logic                     frame_valid,
    output logic                     sync_err,
    output logic                     parity_err
);

    logic                     accept;
    logic [SLOT_IDX_W-1:0]    slot_idx;
    logic                     last_slot;
    logic                     restart;

    logic [DATA_W-1:0]        shadow_q [NUM_CH];
    logic [DATA_W-1:0]        shadow_d [NUM_CH];
    logic [NUM_CH*DATA_W-1:0] frame_flat;
    logic [NUM_CH*DATA_W-1:0] dout_q, dout_d;
    logic                     frame_valid_q, frame_valid_d;
    logic                     sync_err_q, sync_err_d;
`ifdef PARITY_EN
    logic                     parity_err_q, parity_err_d;
    logic [DATA_W-1:0]        parity_acc;
`endif

    tdm_slot_counter u_slot_counter (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .sync      (sync),
        .accept    (accept),
        .slot_idx  (slot_idx),
        .last_slot (last_slot),
        .restart   (restart)
    );

    // Shadow update: the accepted beat overwrites its slot; the packed view
    // includes the current beat so the closing slot is published directly.
    always_comb begin
        for (int k = 0; k < NUM_CH; k++) begin
            shadow_d[k] = shadow_q[k];
            if (accept && (slot_idx == SLOT_IDX_W'(k))) begin
                shadow_d[k] = sdin;
            end
            frame_flat[k*DATA_W +: DATA_W] = shadow_d[k];
        end
    end

    // Frame completion: publish on the closing beat, pulse status flags.
    always_comb begin
        dout_d        = dout_q;
        frame_valid_d = 1'b0;
        sync_err_d    = restart;
`ifdef PARITY_EN
        parity_err_d = 1'b0;
        parity_acc   = sdin;
        for (int k = 0; k < NUM_CH; k++) begin
            parity_acc = parity_acc ^ shadow_q[k];
        end
        if (last_slot) begin
            if (parity_acc == '0) begin
                dout_d        = frame_flat;
                frame_valid_d = 1'b1;
            end else begin
                parity_err_d = 1'b1;
            end
        end
`else
        if (last_slot) begin
            dout_d        = frame_flat;
            frame_valid_d = 1'b1;
        end
`endif
    end

    // Output and shadow registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the shadow is only nine words with a defined reset value,
            // so it sits on the reset net like the rest of the state.
            for (int k = 0; k < NUM_CH; k++) begin
                shadow_q[k] <= '0;
            end
            dout_q        <= '0;
            frame_valid_q <= 1'b0;
            sync_err_q    <= 1'b0;
`ifdef PARITY_EN
            parity_err_q  <= 1'b0;
`endif
        end else begin
            for (int k = 0; k < NUM_CH; k++) begin
                shadow_q[k] <= shadow_d[k];
            end
            dout_q        <= dout_d;
            frame_valid_q <= frame_valid_d;
            sync_err_q    <= sync_err_d;
`ifdef PARITY_EN
            parity_err_q  <= parity_err_d;
`endif
        end
    end

    assign dout        = dout_q;
    assign frame_valid = frame_valid_q;
    assign sync_err    = sync_err_q;
`ifdef PARITY_EN
    assign parity_err  = parity_err_q;
`else
    assign parity_err  = 1'b0;
`endif

endmodule
